// File: rtl/fg_prog_pkg.sv
// Shared types for the floating-gate injection programming sequencer.
package fg_prog_pkg;

   localparam int ROW_W_DEF = 2;
   localparam int COL_W_DEF = 3;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      ADDR    = 3'd2,
      PULSE   = 3'd3,
      GAP     = 3'd4,
      RELEASE = 3'd5,
      DONE    = 3'd6
   } fg_state_e;

   typedef struct packed {
      logic [ROW_W_DEF-1:0] row;
      logic [COL_W_DEF-1:0] col;
      logic [CNT_W_DEF-1:0] pulses;
      logic [CNT_W_DEF-1:0] width;
   } fg_cmd_t;

endpackage

// File: rtl/fg_prog_timer.sv
// Loadable down-counter shared by every timed sequencer state; holds at zero.
module fg_prog_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// Settle/pulse/release sequencer for floating-gate injection programming of one island.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// SETUP   | prog switch closed, decoders still off
// ADDR    | decoders and drain select driven, settling before injection
// PULSE   | Vinj pulse high for the latched width
// GAP     | Vinj low between pulses
// RELEASE | decoders off, prog switch held closed while nodes settle
// DONE    | one-cycle completion strobe with abort status
module fg_prog_sequencer
   import fg_prog_pkg::*;
#(
   parameter int ROW_W      = ROW_W_DEF,
   parameter int COL_W      = COL_W_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int SETTLE_CYC = 4,
   parameter int GAP_CYC    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ROW_W-1:0]    cmd_row,
   input  logic [COL_W-1:0]    cmd_col,
   input  logic [CNT_W-1:0]    cmd_pulses,
   input  logic [CNT_W-1:0]    cmd_width,
   input  logic                abort,
   output logic                prog_en,
   output logic                vdec_en,
   output logic [ROW_W-1:0]    vdec_addr,
   output logic                hdec_en,
   output logic [COL_W-1:0]    hdec_addr,
   output logic [2**ROW_W-1:0] drain_sel,
   output logic                vinj_pulse,
   output logic                busy,
   output logic                done,
   output logic                aborted
);

   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC - 1);

   fg_state_e            state_q, state_d;
   logic [ROW_W-1:0]     row_q, row_d;
   logic [COL_W-1:0]     col_q, col_d;
   logic [CNT_W-1:0]     width_q, width_d;
   logic [CNT_W-1:0]     rem_q, rem_d;
   logic                 flag_q, flag_d;

   logic                 prog_en_q, prog_en_d;
   logic                 vdec_en_q, vdec_en_d;
   logic [ROW_W-1:0]     vdec_addr_q, vdec_addr_d;
   logic                 hdec_en_q, hdec_en_d;
   logic [COL_W-1:0]     hdec_addr_q, hdec_addr_d;
   logic [2**ROW_W-1:0]  drain_sel_q, drain_sel_d;
   logic                 vinj_q, vinj_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 aborted_q, aborted_d;

   logic                 tmr_load;
   logic [CNT_W-1:0]     tmr_val;
   logic                 tmr_zero;
   logic                 dec_on;

   fg_prog_timer #(.W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      width_d  = width_q;
      rem_d    = rem_q;
      flag_d   = flag_q | (abort && (state_q != IDLE));
      tmr_load = 1'b0;
      tmr_val  = SETTLE_LD;

      case (state_q)
         IDLE: begin
            if (cmd_valid && !abort) begin
               row_d    = cmd_row;
               col_d    = cmd_col;
               width_d  = (cmd_width == '0) ? CNT_W'(1) : cmd_width;
               rem_d    = cmd_pulses;
               flag_d   = 1'b0;
               state_d  = SETUP;
               tmr_load = 1'b1;
            end
         end
         SETUP: begin
            if (tmr_zero) begin
               state_d  = ADDR;
               tmr_load = 1'b1;
            end
         end
         ADDR: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               if (rem_q != '0) begin
                  state_d = PULSE;
                  tmr_val = width_q - CNT_W'(1);
               end else begin
                  state_d = RELEASE;
               end
            end
         end
         PULSE: begin
            if (tmr_zero) begin
               // rem_q is nonzero here, so the decrement cannot wrap
               rem_d    = rem_q - CNT_W'(1);
               tmr_load = 1'b1;
               if (rem_q == CNT_W'(1)) begin
                  state_d = RELEASE;
               end else begin
                  state_d = GAP;
                  tmr_val = GAP_LD;
               end
            end
         end
         GAP: begin
            if (tmr_zero) begin
               state_d  = PULSE;
               tmr_load = 1'b1;
               tmr_val  = width_q - CNT_W'(1);
            end
         end
         RELEASE: begin
            if (tmr_zero) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (abort && (state_q inside {SETUP, ADDR, PULSE, GAP})) begin
         state_d  = RELEASE;
         tmr_load = 1'b1;
         tmr_val  = SETTLE_LD;
      end

      // Outputs follow the next state so they change on the same edge as the state.
      dec_on      = state_d inside {ADDR, PULSE, GAP};
      prog_en_d   = state_d inside {SETUP, ADDR, PULSE, GAP, RELEASE};
      vdec_en_d   = dec_on;
      hdec_en_d   = dec_on;
      vdec_addr_d = dec_on ? row_q : '0;
      hdec_addr_d = dec_on ? col_q : '0;
      drain_sel_d = '0;
      if (dec_on) begin
         drain_sel_d[row_q] = 1'b1;
      end
      vinj_d    = (state_d == PULSE);
      busy_d    = (state_d != IDLE);
      done_d    = (state_d == DONE);
      aborted_d = done_d && flag_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         row_q       <= '0;
         col_q       <= '0;
         width_q     <= '0;
         rem_q       <= '0;
         flag_q      <= 1'b0;
         prog_en_q   <= 1'b0;
         vdec_en_q   <= 1'b0;
         vdec_addr_q <= '0;
         hdec_en_q   <= 1'b0;
         hdec_addr_q <= '0;
         drain_sel_q <= '0;
         vinj_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         width_q     <= width_d;
         rem_q       <= rem_d;
         flag_q      <= flag_d;
         prog_en_q   <= prog_en_d;
         vdec_en_q   <= vdec_en_d;
         vdec_addr_q <= vdec_addr_d;
         hdec_en_q   <= hdec_en_d;
         hdec_addr_q <= hdec_addr_d;
         drain_sel_q <= drain_sel_d;
         vinj_q      <= vinj_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         aborted_q   <= aborted_d;
      end
   end

   assign cmd_ready  = (state_q == IDLE);
   assign prog_en    = prog_en_q;
   assign vdec_en    = vdec_en_q;
   assign vdec_addr  = vdec_addr_q;
   assign hdec_en    = hdec_en_q;
   assign hdec_addr  = hdec_addr_q;
   assign drain_sel  = drain_sel_q;
   assign vinj_pulse = vinj_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = aborted_q;

endmodule
